cla_nibble_serial_adder: RTL
============================

Name: cla_nibble_serial_adder

Overview:
Sequencing controller that adds two WIDTH-bit operands over multiple cycles. It time-shares a single 4-bit carry-lookahead slice, processing one nibble per cycle from LSB to MSB and registering the carry between nibbles. It has valid/ready handshakes on both input and output, and sits between an operand source and a result consumer. It is the area-lean alternative to a wide parallel CLA.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, nibble count; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  operand request.
- start_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- c_in  in  1  carry-in, sampled on accept.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- sum  out  WIDTH  registered result.
- c_out  out  1  registered carry-out of the MSB nibble.

Behaviour:
- Reset: state IDLE, res_valid=0, sum=0, c_out=0, internal registers cleared. start_ready is combinational from state, so it is 1 under reset.
- States:
  - IDLE: accept when start_valid & start_ready. a, b and c_in are loaded into shift/carry registers, nibble counter is set to 0, and the next state is RUN.
  - RUN: each cycle the slice adds a_sh[3:0], b_sh[3:0] and the carry register. The slice sum shifts into the top of the sum register, the slice carry-out is stored in the carry register, and a_sh/b_sh shift right by 4. When counter==NIB-1, go to DONE, load c_out from the slice carry and set res_valid=1. Otherwise the counter increments.
  - DONE: res_valid=1, and sum/c_out are held stable. res_ready=1 moves to IDLE and clears res_valid. sum and c_out keep their last value until the next op completes.
- Timing: accept on edge 0, RUN for cycles 1..NIB, res_valid high from cycle NIB+1. Minimum initiation interval is NIB+2 cycles.
- Counter width is max(1, $clog2(NIB)). For WIDTH=4, RUN lasts exactly one cycle.
- Input stability: start_valid and operand inputs are ignored outside IDLE. Operands need only be stable in the accept cycle.
- In DONE with res_ready and start_valid both high: the result is retired and the new request is not accepted. It is accepted in the following IDLE cycle (one bubble).
- Arithmetic is unsigned modulo 2^WIDTH, with c_out being bit WIDTH of a+b+c_in. No overflow flag.
- Asserting rst in any state, including mid-RUN, aborts immediately and asynchronously to reset values. The partial result is discarded.

Optional Feature:
Macro: CLA_NIBBLE_SERIAL_SUB_EN.
- Defined: adds input port sub (1 bit), sampled on accept. When sub=1, b is inverted on load and the carry register is loaded with 1 (c_in ignored). The result is a-b modulo 2^WIDTH, and c_out=1 means no borrow. When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port, addition only.

Decomposition:
- Shared package cla_pkg:
  - state enum typedef (IDLE, RUN, DONE)
  - NIBBLE_W=4 constant
  - function computing counter width from NIB
- One sub-module: the team's existing 4-bit carry-lookahead slice cla (a[3:0], b[3:0], c_in -> s[3:0], c_out), instantiated once as purely combinational logic. All sequencing lives in this block.

Test Plan (WIDTH=16):
- Reset check: assert rst mid-sim -> res_valid=0, sum=0x0000, c_out=0, start_ready=1 while in reset and on the first cycle after release.
- Basic add: a=0x1234, b=0x4321, c_in=0, res_ready=1 -> sum=0x5555, c_out=0. res_valid rises exactly 5 cycles after the accept edge and is high for one cycle.
- Full carry propagation: a=0xFFFF, b=0x0000, c_in=1 -> sum=0x0000, c_out=1. Also a=0xFFFF, b=0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
- Backpressure: a=0x00F0, b=0x0F10, res_ready low 3 cycles after res_valid, start_valid held high with other operands -> sum=0x1000 held stable and start_ready=0 throughout. The retire cycle does not accept; the next request is accepted the cycle after.
- Mid-op reset: rst pulsed during RUN cycle 2 of 0x8888+0x8888 -> immediate IDLE, res_valid never rises. A subsequent 0x0001+0x0001 gives sum=0x0002, c_out=0.
- With CLA_NIBBLE_SERIAL_SUB_EN defined:
  - sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0.
  - sub=1, a=0x0007, b=0x0005 -> sum=0x0002, c_out=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nibble counter width, never narrower than one bit.
  function automatic int cnt_width(input int nib);
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_cla.sv
// Combinational 4-bit carry-lookahead slice shared by the nibble-serial adder.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // All carries are flattened from generate/propagate so none ripples.
  assign w_c[0] = c_in;
  assign w_c[1] = w_g[0] | (w_p[0] & c_in);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & c_in);
  assign c_out  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

  assign s = w_p ^ w_c;

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit CLA slice, LSB nibble first.
// Optional macro CLA_NIBBLE_SERIAL_SUB_EN adds a 'sub' port for a-b (c_out=1 means no borrow).
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef CLA_NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = cnt_width(NIB);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_c_out;
  logic             r_res_valid;

  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;
  logic [WIDTH-1:0] w_a_next;
  logic [3:0]       w_s;
  logic             w_c;
  logic             w_last;

`ifdef CLA_NIBBLE_SERIAL_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : c_in;
`else
  assign w_b_load = b;
  assign w_c_load = c_in;
`endif

  cla u_cla (
    .a     (r_a_sh[NIBBLE_W-1:0]),
    .b     (r_b_sh[NIBBLE_W-1:0]),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_c)
  );

  // The A shifter doubles as the accumulator: consumed nibbles leave the bottom
  // while slice sums enter the top, so after NIB steps it holds the full result.
  generate
    if (WIDTH == NIBBLE_W) begin : g_single
      assign w_a_next = w_s;
    end else begin : g_multi
      assign w_a_next = {w_s, r_a_sh[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  assign w_last      = (r_cnt == CW'(NIB - 1));
  assign start_ready = (r_state == IDLE);
  assign res_valid   = r_res_valid;
  assign sum         = r_sum;
  assign c_out       = r_c_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_c_out     <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh  <= w_a_next;
          r_b_sh  <= r_b_sh >> NIBBLE_W;
          r_carry <= w_c;
          if (w_last) begin
            r_sum       <= w_a_next;
            r_c_out     <= w_c;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // A simultaneous new request is deliberately left for the next IDLE cycle.
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
